// File: rtl/dbi_pkg.sv
// -----------------------------------------------------------------------------
// dbi_pkg
// Shared definitions for the DBI transmit PHY:
//   - phy_state_e     : PHY sequencer states
//   - *_DEF           : default bus width and phase dwell times (clk cycles)
//   - NOP_CMD         : DBI no-operation command byte
//   - max_cyc()       : largest of four cycle counts, used to size the timer
// -----------------------------------------------------------------------------
package dbi_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      HRST     = 3'd1,
      CMD_LO   = 3'd2,
      CMD_HI   = 3'd3,
      DAT_LO   = 3'd4,
      DAT_HI   = 3'd5,
      DAT_WAIT = 3'd6,
      CS_END   = 3'd7
   } phy_state_e;

   localparam int DBI_IF_D_W_DEF   = 8;
   localparam int WR_LOW_CYC_DEF   = 2;
   localparam int WR_HIGH_CYC_DEF  = 2;
   localparam int CS_HIGH_CYC_DEF  = 1;
   localparam int HRST_LOW_CYC_DEF = 1250;

   localparam logic [7:0] NOP_CMD = 8'h00;

   function automatic int max_cyc(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/dbi_phase_timer.sv
// -----------------------------------------------------------------------------
// dbi_phase_timer
// Loadable down-counter that times the dwell of each PHY phase. The owner
// loads (N-1) on the cycle it enters a phase; done is high once the count
// reaches zero, and the counter then holds at zero (never wraps).
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (count -> 0)
//   load     in   load load_val on the next edge
//   load_val in   CNT_W  value to load
//   done     out  count is zero
// -----------------------------------------------------------------------------
module dbi_phase_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/dbi_tx_phy.sv
// -----------------------------------------------------------------------------
// dbi_tx_phy
// MIPI-DBI (type B, write-only) transmit PHY. Accepts command/data beats on a
// valid/ready handshake and sequences CSX/DCX/WRX/D on the panel bus, or
// pulses RESX for a hardware-reset beat.
// Optional build macro: DBI_TX_PHY_OUT_REG_EN -- registers all dbi_* pins
// through one extra flop stage (one cycle of added latency).
// Ports:
//   clk, rst_n            clock / asynchronous active-low reset
//   dtp_dbi_hrst_i        beat requests a panel hardware reset
//   dtp_tx_cmd_typ_i      command byte (first beat only)
//   dtp_tx_cmd_dat_i      data byte
//   dtp_tx_last_i         last beat of the transaction
//   dtp_tx_no_dat_i       command-only transaction
//   dtp_tx_vld_i          beat valid
//   dtp_tx_rdy_o          PHY accepts a beat (state decode only)
//   dbi_resx_o            panel reset, active-low
//   dbi_csx_o             chip select, active-low
//   dbi_dcx_o             0 = command, 1 = data
//   dbi_wrx_o             write strobe, panel latches on rising edge
//   dbi_d_o               data bus
// -----------------------------------------------------------------------------
module dbi_tx_phy
   import dbi_pkg::*;
#(
   parameter int DBI_IF_D_W   = DBI_IF_D_W_DEF,
   parameter int WR_LOW_CYC   = WR_LOW_CYC_DEF,
   parameter int WR_HIGH_CYC  = WR_HIGH_CYC_DEF,
   parameter int CS_HIGH_CYC  = CS_HIGH_CYC_DEF,
   parameter int HRST_LOW_CYC = HRST_LOW_CYC_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  dtp_dbi_hrst_i,
   input  logic [DBI_IF_D_W-1:0] dtp_tx_cmd_typ_i,
   input  logic [DBI_IF_D_W-1:0] dtp_tx_cmd_dat_i,
   input  logic                  dtp_tx_last_i,
   input  logic                  dtp_tx_no_dat_i,
   input  logic                  dtp_tx_vld_i,
   output logic                  dtp_tx_rdy_o,
   output logic                  dbi_resx_o,
   output logic                  dbi_csx_o,
   output logic                  dbi_dcx_o,
   output logic                  dbi_wrx_o,
   output logic [DBI_IF_D_W-1:0] dbi_d_o
);

   localparam int MAX_CYC = max_cyc(WR_LOW_CYC, WR_HIGH_CYC, CS_HIGH_CYC, HRST_LOW_CYC);
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;

   phy_state_e            state, state_nxt;
   logic                  acc;
   logic                  done;
   logic                  load;
   logic [CNT_W-1:0]      load_val;

   logic [DBI_IF_D_W-1:0] cmd_q, dat_q;
   logic                  last_q, no_dat_q;
   logic                  sel_dat_q;   // bus shows dat_q (1) or cmd_q (0)

   logic                  resx_c, csx_c, dcx_c, wrx_c;
   logic [DBI_IF_D_W-1:0] d_c;

   assign dtp_tx_rdy_o = (state == IDLE) || (state == DAT_WAIT);
   assign acc          = dtp_tx_vld_i & dtp_tx_rdy_o;

   dbi_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (load_val),
      .done     (done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      resx_c    = 1'b1;
      csx_c     = 1'b1;
      dcx_c     = 1'b1;
      wrx_c     = 1'b1;
      case (state)
         IDLE:     if (acc) state_nxt = dtp_dbi_hrst_i ? HRST : CMD_LO;
         HRST: begin
            resx_c = 1'b0;
            if (done) state_nxt = IDLE;
         end
         CMD_LO: begin
            csx_c = 1'b0; dcx_c = 1'b0; wrx_c = 1'b0;
            if (done) state_nxt = CMD_HI;
         end
         CMD_HI: begin
            csx_c = 1'b0; dcx_c = 1'b0;
            if (done) state_nxt = no_dat_q ? CS_END : DAT_LO;
         end
         DAT_LO: begin
            csx_c = 1'b0; wrx_c = 1'b0;
            if (done) state_nxt = DAT_HI;
         end
         DAT_HI: begin
            csx_c = 1'b0;
            if (done) state_nxt = last_q ? CS_END : DAT_WAIT;
         end
         DAT_WAIT: begin
            csx_c = 1'b0;
            if (acc) state_nxt = DAT_LO;
         end
         CS_END:   if (done) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Timer is reloaded with (dwell-1) on every state change so that the new
   // state sees its full dwell starting from its first cycle.
   always_comb begin
      load     = (state_nxt != state);
      load_val = '0;
      case (state_nxt)
         HRST:           load_val = CNT_W'(HRST_LOW_CYC - 1);
         CMD_LO, DAT_LO: load_val = CNT_W'(WR_LOW_CYC - 1);
         CMD_HI, DAT_HI: load_val = CNT_W'(WR_HIGH_CYC - 1);
         CS_END:         load_val = CNT_W'(CS_HIGH_CYC - 1);
         default:        load_val = '0;
      endcase
   end

   // Beat capture. A reset beat leaves every field untouched so the bus keeps
   // its last value; a DAT_WAIT beat only supplies data and last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q     <= '0;
         dat_q     <= '0;
         last_q    <= 1'b0;
         no_dat_q  <= 1'b0;
         sel_dat_q <= 1'b0;
      end else begin
         if (acc && (state == IDLE) && !dtp_dbi_hrst_i) begin
            cmd_q    <= dtp_tx_cmd_typ_i;
            dat_q    <= dtp_tx_cmd_dat_i;
            no_dat_q <= dtp_tx_no_dat_i;
            last_q   <= dtp_tx_last_i | dtp_tx_no_dat_i;
         end else if (acc && (state == DAT_WAIT)) begin
            dat_q    <= dtp_tx_cmd_dat_i;
            last_q   <= dtp_tx_last_i;
         end
         if ((state_nxt == CMD_LO) && (state != CMD_LO))      sel_dat_q <= 1'b0;
         else if ((state_nxt == DAT_LO) && (state != DAT_LO)) sel_dat_q <= 1'b1;
      end
   end

   assign d_c = sel_dat_q ? dat_q : cmd_q;

`ifdef DBI_TX_PHY_OUT_REG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dbi_resx_o <= 1'b1;
         dbi_csx_o  <= 1'b1;
         dbi_dcx_o  <= 1'b1;
         dbi_wrx_o  <= 1'b1;
         dbi_d_o    <= '0;
      end else begin
         dbi_resx_o <= resx_c;
         dbi_csx_o  <= csx_c;
         dbi_dcx_o  <= dcx_c;
         dbi_wrx_o  <= wrx_c;
         dbi_d_o    <= d_c;
      end
   end
`else
   assign dbi_resx_o = resx_c;
   assign dbi_csx_o  = csx_c;
   assign dbi_dcx_o  = dcx_c;
   assign dbi_wrx_o  = wrx_c;
   assign dbi_d_o    = d_c;
`endif

endmodule

// File: tb/tb_dbi_tx_phy.sv
// -----------------------------------------------------------------------------
// tb_dbi_tx_phy
// Bench for dbi_tx_phy. A pin monitor turns the bus into a log of panel
// writes {dcx,d}, RESX low pulse lengths and CSX release count; a transaction
// model builds the same log from the beats that were sent.
// -----------------------------------------------------------------------------
module tb_dbi_tx_phy;

`ifdef DBI_TX_PHY_OUT_REG_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif
   localparam int HRST_N = 10;

   logic       clk;
   logic       rst_n;
   logic       hrst, last, no_dat, vld;
   logic [7:0] cmd, dat;
   logic       rdy, resx, csx, dcx, wrx;
   logic [7:0] d;

   int tests = 0;
   int fails = 0;

   logic [8:0] exp_wr[$];
   logic [8:0] got_wr[$];
   int         rst_len[$];
   int         exp_hrst = 0;
   int         exp_cs   = 0;
   int         cs_rises = 0;
   logic [7:0] dat_buf[4];

   logic       s_rdy[1:16], s_csx[1:16], s_wrx[1:16], s_dcx[1:16], s_resx[1:16];
   logic [7:0] s_d[1:16];

   dbi_tx_phy #(
      .DBI_IF_D_W(8), .WR_LOW_CYC(2), .WR_HIGH_CYC(2),
      .CS_HIGH_CYC(1), .HRST_LOW_CYC(HRST_N)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .dtp_dbi_hrst_i   (hrst),
      .dtp_tx_cmd_typ_i (cmd),
      .dtp_tx_cmd_dat_i (dat),
      .dtp_tx_last_i    (last),
      .dtp_tx_no_dat_i  (no_dat),
      .dtp_tx_vld_i     (vld),
      .dtp_tx_rdy_o     (rdy),
      .dbi_resx_o       (resx),
      .dbi_csx_o        (csx),
      .dbi_dcx_o        (dcx),
      .dbi_wrx_o        (wrx),
      .dbi_d_o          (d)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pin monitor, sampled on the falling edge.
   logic p_wrx = 1'b1;
   logic p_csx = 1'b1;
   int   lo_cnt = 0;
   always @(negedge clk) begin
      if (!p_wrx && wrx && !csx) got_wr.push_back({dcx, d});
      if (!p_csx && csx) cs_rises++;
      if (resx === 1'b0) begin
         lo_cnt++;
         chk("hrst_csx_high", {31'd0, csx}, 32'd1);
         chk("hrst_wrx_high", {31'd0, wrx}, 32'd1);
      end else if (lo_cnt != 0) begin
         rst_len.push_back(lo_cnt);
         lo_cnt = 0;
      end
      if (rdy === 1'b1) chk("rdy_implies_wrx_high", {31'd0, wrx}, 32'd1);
      p_wrx = wrx;
      p_csx = csx;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample_run(input int n);
      for (int k = 1; k <= n; k++) begin
         s_rdy[k] = rdy; s_csx[k] = csx; s_wrx[k] = wrx;
         s_dcx[k] = dcx; s_resx[k] = resx; s_d[k] = d;
         tick();
      end
   endtask

   // Presents one beat and waits (bounded) for the accepting edge; returns
   // one cycle after acceptance. keep leaves vld high for a following beat.
   task automatic send_beat(input logic h, input logic [7:0] c, input logic [7:0] dt,
                            input logic l, input logic nd, input bit keep);
      bit ok;
      ok = 1'b0;
      hrst = h; cmd = c; dat = dt; last = l; no_dat = nd; vld = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         if (rdy === 1'b1) begin
            tick();
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk("beat_accepted", {31'd0, ok}, 32'd1);
      if (!keep) vld = 1'b0;
   endtask

   // Sends a whole transaction and records what the panel must see.
   task automatic send_txn(input bit h, input logic [7:0] c, input int n_dat,
                           input bit nd, input bit nd_last, input int gap, input bit keep_end);
      if (h) begin
         exp_hrst++;
         send_beat(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), keep_end);
         return;
      end
      exp_cs++;
      exp_wr.push_back({1'b0, c});
      if (nd) begin
         send_beat(1'b0, c, dat_buf[0], nd_last, 1'b1, keep_end);
         return;
      end
      for (int i = 0; i < n_dat; i++) exp_wr.push_back({1'b1, dat_buf[i]});
      send_beat(1'b0, c, dat_buf[0], (n_dat == 1), 1'b0,
                (n_dat == 1) ? keep_end : (gap == 0));
      for (int i = 1; i < n_dat; i++) begin
         repeat (gap) tick();
         send_beat(1'($urandom), 8'($urandom), dat_buf[i], (i == n_dat - 1), 1'b0,
                   (i == n_dat - 1) ? keep_end : (gap == 0));
      end
   endtask

   initial begin
      rst_n = 1'b1;
      hrst = 1'b0; cmd = '0; dat = '0; last = 1'b0; no_dat = 1'b0; vld = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      // Reset state
      chk("reset_rdy",  {31'd0, rdy},  32'd1);
      chk("reset_csx",  {31'd0, csx},  32'd1);
      chk("reset_dcx",  {31'd0, dcx},  32'd1);
      chk("reset_wrx",  {31'd0, wrx},  32'd1);
      chk("reset_resx", {31'd0, resx}, 32'd1);
      chk("reset_d",    {24'd0, d},    32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // Command-only 0x29
      send_txn(1'b0, 8'h29, 0, 1'b1, 1'b1, 0, 1'b0);
      sample_run(8);
      for (int k = 1; k <= 5; k++) chk("cmdonly_rdy_low", {31'd0, s_rdy[k]}, 32'd0);
      chk("cmdonly_rdy_back_c6", {31'd0, s_rdy[6]}, 32'd1);
      for (int k = 1; k <= 4; k++) begin
         chk("cmdonly_csx_low", {31'd0, s_csx[k+LAT]}, 32'd0);
         chk("cmdonly_dcx_cmd", {31'd0, s_dcx[k+LAT]}, 32'd0);
         chk("cmdonly_d",       {24'd0, s_d[k+LAT]},   32'h29);
         chk("cmdonly_wrx",     {31'd0, s_wrx[k+LAT]}, (k <= 2) ? 32'd0 : 32'd1);
      end
      chk("cmdonly_csx_end", {31'd0, s_csx[5+LAT]}, 32'd1);

      // HW reset pulse
      send_txn(1'b1, 8'h00, 0, 1'b0, 1'b0, 0, 1'b0);
      sample_run(12);
      for (int k = 1; k <= HRST_N; k++) begin
         chk("hrst_rdy_low", {31'd0, s_rdy[k]},      32'd0);
         chk("hrst_resx_low", {31'd0, s_resx[k+LAT]}, 32'd0);
      end
      chk("hrst_rdy_back",  {31'd0, s_rdy[HRST_N+1]},      32'd1);
      chk("hrst_resx_high", {31'd0, s_resx[HRST_N+1+LAT]}, 32'd1);

      // 3-byte write with DAT_WAIT gaps
      dat_buf[0] = 8'h00; dat_buf[1] = 8'h01; dat_buf[2] = 8'h3F;
      send_txn(1'b0, 8'h2A, 3, 1'b0, 1'b0, 3, 1'b0);
      repeat (8) tick();

      // Back-pressure: vld held high across two transactions
      dat_buf[0] = 8'h11; dat_buf[1] = 8'h22; dat_buf[2] = 8'h33;
      send_txn(1'b0, 8'h2B, 3, 1'b0, 1'b0, 0, 1'b1);
      send_txn(1'b0, 8'h29, 0, 1'b1, 1'b1, 0, 1'b0);
      repeat (8) tick();

      // rst_n pulsed in DAT_LO aborts the data write
      exp_cs++;
      exp_wr.push_back({1'b0, 8'hB7});
      send_beat(1'b0, 8'hB7, 8'h5A, 1'b1, 1'b0, 1'b0);
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      chk("abort_wrx",  {31'd0, wrx},  32'd1);
      chk("abort_csx",  {31'd0, csx},  32'd1);
      chk("abort_dcx",  {31'd0, dcx},  32'd1);
      chk("abort_resx", {31'd0, resx}, 32'd1);
      chk("abort_d",    {24'd0, d},    32'd0);
      chk("abort_rdy",  {31'd0, rdy},  32'd1);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      send_txn(1'b0, 8'h2C, 0, 1'b1, 1'b1, 0, 1'b0);
      sample_run(4);
      chk("post_abort_dcx", {31'd0, s_dcx[1+LAT]}, 32'd0);
      chk("post_abort_d",   {24'd0, s_d[1+LAT]},   32'h2C);

      // no_dat=1 with last=0 ends after the command byte
      dat_buf[0] = 8'hAA;
      send_txn(1'b0, 8'h10, 1, 1'b1, 1'b0, 0, 1'b0);
      sample_run(7);
      chk("nodat_csx_end", {31'd0, s_csx[5+LAT]}, 32'd1);
      chk("nodat_rdy_c6",  {31'd0, s_rdy[6]},     32'd1);

      // Randomized transactions
      for (int t = 0; t < 25; t++) begin
         int  r, n, g;
         bit  ke;
         r  = $urandom_range(0, 9);
         n  = $urandom_range(1, 4);
         g  = $urandom_range(0, 3);
         ke = (t == 24) ? 1'b0 : 1'($urandom);
         for (int i = 0; i < 4; i++) dat_buf[i] = 8'($urandom);
         if (r == 0)      send_txn(1'b1, 8'($urandom), 0, 1'b0, 1'b0, 0, ke);
         else if (r <= 3) send_txn(1'b0, 8'($urandom), 1, 1'b1, 1'($urandom), 0, ke);
         else             send_txn(1'b0, 8'($urandom), n, 1'b0, 1'b0, g, ke);
         if (!ke) repeat ($urandom_range(0, 2)) tick();
      end
      vld = 1'b0;
      repeat (30) tick();

      // Compare logs against the model
      chk("write_count", got_wr.size(), exp_wr.size());
      for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
         chk($sformatf("write_%0d", i), {23'd0, got_wr[i]}, {23'd0, exp_wr[i]});
      chk("hrst_pulse_count", rst_len.size(), exp_hrst);
      foreach (rst_len[i]) chk("hrst_pulse_len", rst_len[i], HRST_N);
      chk("csx_release_count", cs_rises, exp_cs);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dbi_tx_phy.md
DBI_TX_PHY -- requirements
Module: dbi_tx_phy

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- DBI_IF_D_W, 8, DBI data bus width.
- WR_LOW_CYC, 2, clk cycles WRX is held low per write.
- WR_HIGH_CYC, 2, clk cycles WRX is held high per write.
- CS_HIGH_CYC, 1, minimum clk cycles CSX is held high after a transaction.
- HRST_LOW_CYC, 1250, clk cycles RESX is held low for a HW reset.
- All *_CYC parameters SHALL be >= 1.

REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, sole clock; all logic is on the rising edge.
- rst_n, in, 1, reset, asynchronous and active-low.
- dtp_dbi_hrst_i, in, 1, beat is a HW-reset request.
- dtp_tx_cmd_typ_i, in, DBI_IF_D_W, command byte.
- dtp_tx_cmd_dat_i, in, DBI_IF_D_W, data byte.
- dtp_tx_last_i, in, 1, last beat of the transaction.
- dtp_tx_no_dat_i, in, 1, command-only transaction.
- dtp_tx_vld_i, in, 1, beat valid.
- dtp_tx_rdy_o, out, 1, PHY accepts a beat.
- dbi_resx_o, out, 1, panel reset, active-low.
- dbi_csx_o, out, 1, chip select, active-low.
- dbi_dcx_o, out, 1, 0 = command, 1 = data.
- dbi_wrx_o, out, 1, write strobe; the panel latches on the rising edge.
- dbi_d_o, out, DBI_IF_D_W, DBI data bus.

Function
REQ-003 A beat SHALL be accepted on a clk edge where dtp_tx_vld_i & dtp_tx_rdy_o; the accepted fields SHALL be captured into internal registers.
REQ-004 dtp_tx_rdy_o SHALL be decoded from state only (no combinational path from any input), and SHALL be 1 only in IDLE and DAT_WAIT.
REQ-005 The states SHALL be IDLE, HRST, CMD_LO, CMD_HI, DAT_LO, DAT_HI, DAT_WAIT, CS_END.
REQ-006 The pin values per state SHALL be:
- IDLE: csx=1, dcx=1, wrx=1, resx=1; d holds its last value.
- HRST: resx=0, csx=1, wrx=1.
- CMD_LO / CMD_HI: csx=0, dcx=0, d=captured cmd; wrx=0 in CMD_LO and wrx=1 in CMD_HI.
- DAT_LO / DAT_HI: csx=0, dcx=1, d=captured data; wrx=0 in DAT_LO and wrx=1 in DAT_HI.
- DAT_WAIT: csx=0, dcx=1, wrx=1.
- CS_END: csx=1, wrx=1.
REQ-007 Transitions out of IDLE on an accepted beat SHALL be: if hrst=1, go to HRST; else go to CMD_LO. The pins SHALL change in the first cycle after acceptance.
REQ-008 HRST SHALL last HRST_LOW_CYC cycles and then go to IDLE. The cmd, data, last and no_dat fields of a HRST beat SHALL be ignored.
REQ-009 State dwell times SHALL be exact:
- CMD_LO and DAT_LO: WR_LOW_CYC cycles each.
- CMD_HI and DAT_HI: WR_HIGH_CYC cycles each.
- CS_END: CS_HIGH_CYC cycles, then IDLE.
REQ-010 Transitions after the write phases SHALL be:
- From CMD_HI: go to CS_END if no_dat=1, else to DAT_LO, which sends the data byte of the same first beat.
- From DAT_HI: go to CS_END if the captured last=1, else to DAT_WAIT.
REQ-011 In DAT_WAIT an accepted beat SHALL go to DAT_LO with the new data byte. Its cmd_typ and hrst fields SHALL be ignored; CSX SHALL stay low.
REQ-012 no_dat=1 SHALL imply last, regardless of dtp_tx_last_i.
REQ-013 The phase counter SHALL be $clog2(max *_CYC)+1 bits wide, SHALL load (N-1) on state entry, decrement, and advance the state at 0; no wrap-around SHALL be visible.

Reset
REQ-014 While rst_n=0 the block SHALL go immediately to IDLE, with:
- dtp_tx_rdy_o = 1 (IDLE decode).
- csx = dcx = wrx = resx = 1.
- d = 0.
- phase counter = 0.
REQ-015 Reset asserted mid-transaction SHALL abort the transaction; any partial WRX low pulse SHALL end with WRX=1 asynchronously.

Configuration
REQ-016 With DBI_TX_PHY_OUT_REG_EN defined, all dbi_* outputs SHALL pass through one flop stage. The shifted pins keep relative timing, add one cycle of latency, and reset to the REQ-014 values.
REQ-017 Without DBI_TX_PHY_OUT_REG_EN, the dbi_* outputs SHALL be decoded directly from the state registers and capture registers, with zero added latency.

Structure
REQ-018 Package dbi_pkg SHALL hold:
- the PHY state enum;
- DBI_IF_D_W default;
- the cycle-count defaults;
- the NOP_CMD constant (8'h00).
REQ-019 Sub-module dbi_phase_timer SHALL provide the loadable down-counter with a done flag. Everything else SHALL be in dbi_tx_phy.

Verification
REQ-020 The bench SHALL use WR_LOW_CYC=2, WR_HIGH_CYC=2, CS_HIGH_CYC=1 and HRST_LOW_CYC=10, and SHALL cover:
- Command-only: beat {cmd=8'h29, no_dat=1, last=1} -> CSX low 4 cycles, DCX=0, D=8'h29, WRX 0,0,1,1; CSX high 1 cycle; rdy back at cycle 6.
- 3-byte write: beats {8'h2A, 8'h00, last=0}, {x, 8'h01, last=0}, {x, 8'h3F, last=1} -> 4 WRX rising edges with D = 2A/00/01/3F and DCX = 0/1/1/1; CSX low throughout, including DAT_WAIT gaps.
- HW reset: hrst=1 beat -> RESX low exactly 10 cycles; CSX and WRX stay 1; rdy=0 during HRST.
- Back-pressure: vld held high continuously -> rdy asserted only in IDLE/DAT_WAIT; no beat lost or duplicated.
- rst_n pulsed during DAT_LO -> all pins return to reset values at once; next beat is treated as a new command.
- no_dat=1 with last=0 -> transaction ends after the command byte (REQ-012).
